// File: rtl/ysyx_040066_dmem_resp.sv
// ysyx_040066_dmem_resp: fixed-latency data memory responder for the CPU data port
module ysyx_040066_dmem_resp #(
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int          DEPTH   = 1024,
    parameter int          LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic [63:0] addr,
    input  logic [2:0]  wr_len,
    input  logic [7:0]  wr_mask,
    input  logic [63:0] data_Wr,
    output logic [63:0] data_Rd,
    output logic        data_valid,
    output logic        data_error
);
    localparam int              AW       = $clog2(DEPTH);
    localparam int              CW       = $clog2(LATENCY + 1);
    localparam logic [63:0]     LIMIT    = BASE + 64'(DEPTH) * 64'd8;
    localparam logic [CW-1:0]   CNT_INIT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            wr_q, wr_d, err_q, err_d;
    logic [7:0]      mask_q, mask_d;
    logic [63:0]     wdata_q, wdata_d;
    logic [63:0]     data_rd_q, data_rd_d;
    logic            valid_q, valid_d, error_q, error_d;
    logic [63:0]     mem [DEPTH];
    logic            idle, req, in_err, go_resp, cur_wr, cur_err;
    logic [AW-1:0]   in_idx, cur_idx;
    logic [7:0]      cur_mask;
    logic [63:0]     cur_wdata, merged;

    // Decode the live request: word index and every fault condition, evaluated at accept
    always_comb begin
        in_idx = AW'((addr - BASE) >> 3);
        in_err = (addr < BASE) || (addr >= LIMIT) || (wr_len > 3'd3)
              || ((addr[2:0] & ~(3'b111 << wr_len[1:0])) != 3'b0) || (MemRd && MemWr);
    end

    // FSM next state, request latching and registered response; the live request is
    // used directly when a LATENCY of 1 jumps from IDLE straight into RESP
    always_comb begin
        idle      = state_q == IDLE;
        req       = MemRd || MemWr;
        cur_idx   = idle ? in_idx  : idx_q;
        cur_wr    = idle ? MemWr   : wr_q;
        cur_err   = idle ? in_err  : err_q;
        cur_mask  = idle ? wr_mask : mask_q;
        cur_wdata = idle ? data_Wr : wdata_q;
        go_resp   = (idle && req && LATENCY == 1) || (state_q == WAIT && cnt_q == CW'(1));
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wr_d      = wr_q;
        err_d     = err_q;
        mask_d    = mask_q;
        wdata_d   = wdata_q;
        case (state_q)
            IDLE: if (req) begin
                idx_d   = in_idx;
                wr_d    = MemWr;
                err_d   = in_err;
                mask_d  = wr_mask;
                wdata_d = data_Wr;
                cnt_d   = CNT_INIT;
                state_d = (LATENCY == 1) ? RESP : WAIT;
            end
            WAIT: begin
                cnt_d   = cnt_q - CW'(1);
                state_d = (cnt_q == CW'(1)) ? RESP : WAIT;
            end
            default: state_d = IDLE;
        endcase
        for (int k = 0; k < 8; k++)
            merged[8*k +: 8] = cur_mask[k] ? cur_wdata[8*k +: 8] : mem[cur_idx][8*k +: 8];
        valid_d   = go_resp;
        error_d   = go_resp && cur_err;
        data_rd_d = (go_resp && !cur_wr && !cur_err) ? mem[cur_idx] : 64'b0;
    end

    // State and output registers; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            mask_q    <= '0;
            wdata_q   <= '0;
            data_rd_q <= '0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            wr_q      <= wr_d;
            err_q     <= err_d;
            mask_q    <= mask_d;
            wdata_q   <= wdata_d;
            data_rd_q <= data_rd_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
        end
    end

    // Write commits on entry to RESP so a following read of the same word sees it
    always_ff @(posedge clk) begin
        if (!rst && go_resp && cur_wr && !cur_err)
            mem[cur_idx] <= merged;
    end

    assign data_Rd    = data_rd_q;
    assign data_valid = valid_q;
    assign data_error = error_q;
endmodule

// File: tb/tb_ysyx_040066_dmem_resp.sv
// tb_ysyx_040066_dmem_resp: scoreboard bench for the data memory responder at latencies 2, 1 and 4
module tb_ysyx_040066_dmem_resp;
    typedef struct {
        int          d;
        logic        e;
        logic [63:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd [3];
    logic        wr [3];
    logic [63:0] ad [3];
    logic [2:0]  ln [3];
    logic [7:0]  mk [3];
    logic [63:0] wd [3];
    logic [63:0] rdata [3];
    logic        dv [3];
    logic        de [3];
    int          lat_of [3] = '{2, 1, 4};
    int          pulses [3] = '{0, 0, 0};
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    exp_t        sbq [$];
    exp_t        x;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ysyx_040066_dmem_resp #(.LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .MemRd(rd[0]), .MemWr(wr[0]), .addr(ad[0]), .wr_len(ln[0]),
        .wr_mask(mk[0]), .data_Wr(wd[0]), .data_Rd(rdata[0]), .data_valid(dv[0]), .data_error(de[0]));
    ysyx_040066_dmem_resp #(.LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .MemRd(rd[1]), .MemWr(wr[1]), .addr(ad[1]), .wr_len(ln[1]),
        .wr_mask(mk[1]), .data_Wr(wd[1]), .data_Rd(rdata[1]), .data_valid(dv[1]), .data_error(de[1]));
    ysyx_040066_dmem_resp #(.LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .MemRd(rd[2]), .MemWr(wr[2]), .addr(ad[2]), .wr_len(ln[2]),
        .wr_mask(mk[2]), .data_Wr(wd[2]), .data_Rd(rdata[2]), .data_valid(dv[2]), .data_error(de[2]));

    // Every response pulse is matched against the oldest expected entry
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (dv[d] === 1'b1) begin
                pulses[d] = pulses[d] + 1;
                n_cmp = n_cmp + 1;
                if (sbq.size() == 0 || sbq[0].d != d) begin
                    n_err = n_err + 1;
                    $display("FAIL unexpected_valid dut%0d at cycle %0d", d, cyc);
                end else begin
                    x = sbq.pop_front();
                    if (de[d] !== x.e || rdata[d] !== x.data || cyc !== x.due) begin
                        n_err = n_err + 1;
                        $display("FAIL resp dut%0d got err=%b data=%h cycle=%0d, expected err=%b data=%h cycle=%0d",
                                 d, de[d], rdata[d], cyc, x.e, x.data, x.due);
                    end
                end
            end
        end
    end

    task automatic access(input int d, input logic r, input logic w, input logic [63:0] a,
                          input logic [2:0] len, input logic [7:0] m, input logic [63:0] wdat,
                          input logic e, input logic [63:0] xd);
        int p0;
        p0 = pulses[d];
        @(posedge clk); #1;
        rd[d] = r; wr[d] = w; ad[d] = a; ln[d] = len; mk[d] = m; wd[d] = wdat;
        sbq.push_back('{d, e, xd, cyc + lat_of[d]});
        for (int i = 0; i < 20 && pulses[d] == p0; i++) begin
            @(negedge clk); #1;
        end
        if (pulses[d] == p0) begin
            n_cmp = n_cmp + 1;
            n_err = n_err + 1;
            $display("FAIL timeout dut%0d addr=%h got no data_valid, expected one", d, a);
            sbq.delete();
        end
        @(posedge clk); #1;
        rd[d] = 1'b0; wr[d] = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_cmp = n_cmp + 1;
            if ({dv[d], de[d], rdata[d]} !== 66'b0) begin
                n_err = n_err + 1;
                $display("FAIL reset dut%0d got valid=%b err=%b data=%h, expected all zero", d, dv[d], de[d], rdata[d]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        access(0, 0, 1, 64'h8000_0010, 3, 8'hFF, 64'h1122_3344_5566_7788, 0, 64'h0);
        access(0, 1, 0, 64'h8000_0010, 3, 8'h00, 64'h0, 0, 64'h1122_3344_5566_7788);
    endtask

    task automatic test_byte_write();
        access(0, 0, 1, 64'h8000_0013, 0, 8'h08, 64'h0000_0000_AB00_0000, 0, 64'h0);
        access(0, 1, 0, 64'h8000_0010, 3, 8'h00, 64'h0, 0, 64'h1122_3344_AB66_7788);
    endtask

    task automatic test_errors();
        access(0, 1, 0, 64'h7FFF_FFF8, 3, 8'h00, 64'h0, 1, 64'h0);
        access(0, 1, 0, 64'h8000_2000, 3, 8'h00, 64'h0, 1, 64'h0);
        access(0, 1, 0, 64'h8000_0012, 2, 8'h00, 64'h0, 1, 64'h0);
        access(0, 1, 1, 64'h8000_0010, 3, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h0);
        access(0, 0, 1, 64'h8000_0010, 4, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h0);
        access(0, 0, 1, 64'h8000_0011, 1, 8'h06, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h0);
        access(0, 1, 0, 64'h8000_0010, 3, 8'h00, 64'h0, 0, 64'h1122_3344_AB66_7788);
        access(0, 0, 1, 64'h8000_1FF8, 3, 8'hFF, 64'h0000_0000_0000_BEEF, 0, 64'h0);
        access(0, 1, 0, 64'h8000_1FF8, 3, 8'h00, 64'h0, 0, 64'h0000_0000_0000_BEEF);
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = pulses[0];
        @(posedge clk); #1;
        rd[0] = 1'b1; wr[0] = 1'b0; ad[0] = 64'h8000_0010; ln[0] = 3'd3; mk[0] = 8'h00;
        sbq.push_back('{0, 1'b0, 64'h1122_3344_AB66_7788, cyc + 2});
        sbq.push_back('{0, 1'b0, 64'h1122_3344_AB66_7788, cyc + 5});
        for (int i = 0; i < 30 && pulses[0] < p0 + 2; i++) begin
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        rd[0] = 1'b0;
        repeat (6) @(posedge clk);
        n_cmp = n_cmp + 1;
        if (pulses[0] - p0 !== 2) begin
            n_err = n_err + 1;
            $display("FAIL back_to_back_count got %0d pulses, expected 2", pulses[0] - p0);
            sbq.delete();
        end
    endtask

    task automatic test_reset_midop();
        int p0;
        access(0, 0, 1, 64'h8000_0018, 3, 8'hFF, 64'h0123_4567_89AB_CDEF, 0, 64'h0);
        p0 = pulses[0];
        @(posedge clk); #1;
        wr[0] = 1'b1; ad[0] = 64'h8000_0018; ln[0] = 3'd3; mk[0] = 8'hFF; wd[0] = 64'h0000_0000_0000_DEAD;
        @(posedge clk); #1;
        rst = 1'b1; wr[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        n_cmp = n_cmp + 1;
        if (pulses[0] !== p0) begin
            n_err = n_err + 1;
            $display("FAIL reset_abort got %0d pulses, expected 0", pulses[0] - p0);
        end
        access(0, 1, 0, 64'h8000_0018, 3, 8'h00, 64'h0, 0, 64'h0123_4567_89AB_CDEF);
    endtask

    task automatic test_latency1();
        access(1, 0, 1, 64'h8000_0008, 3, 8'hFF, 64'h0000_0000_0000_0001, 0, 64'h0);
        access(1, 1, 0, 64'h8000_0008, 3, 8'h00, 64'h0, 0, 64'h0000_0000_0000_0001);
        access(1, 1, 0, 64'h8000_0009, 1, 8'h00, 64'h0, 1, 64'h0);
    endtask

    task automatic test_wait_ignore();
        int p0;
        access(2, 0, 1, 64'h8000_0010, 3, 8'hFF, 64'hA5A5_5A5A_0F0F_F0F0, 0, 64'h0);
        p0 = pulses[2];
        @(posedge clk); #1;
        rd[2] = 1'b1; wr[2] = 1'b0; ad[2] = 64'h8000_0010; ln[2] = 3'd3; mk[2] = 8'h00;
        sbq.push_back('{2, 1'b0, 64'hA5A5_5A5A_0F0F_F0F0, cyc + 4});
        @(posedge clk); #1;
        rd[2] = 1'b0; wr[2] = 1'b1; ad[2] = 64'h7FFF_0000; mk[2] = 8'hFF; wd[2] = 64'h0;
        for (int i = 0; i < 20 && pulses[2] == p0; i++) begin
            @(negedge clk); #1;
        end
        n_cmp = n_cmp + 1;
        if (pulses[2] == p0) begin
            n_err = n_err + 1;
            $display("FAIL wait_ignore_timeout got no data_valid, expected one");
            sbq.delete();
        end
        @(posedge clk); #1;
        rd[2] = 1'b0; wr[2] = 1'b0;
        access(2, 1, 0, 64'h8000_0010, 3, 8'h00, 64'h0, 0, 64'hA5A5_5A5A_0F0F_F0F0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            rd[d] = 1'b0; wr[d] = 1'b0; ad[d] = '0; ln[d] = '0; mk[d] = '0; wd[d] = '0;
        end
        test_reset();
        test_write_read();
        test_byte_write();
        test_errors();
        test_back_to_back();
        test_reset_midop();
        test_latency1();
        test_wait_ignore();
        repeat (4) @(posedge clk);
        n_cmp = n_cmp + 1;
        if (sbq.size() != 0) begin
            n_err = n_err + 1;
            $display("FAIL leftover_expected got %0d pending, expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
